// File: rtl/gain_ramp_pkg.sv
// Shared definitions for the gain ramp and its attenuator (package gabella_gain_pkg).
// The attenuator and gain_ramp both take DEFAULT_MULT_W so their coefficient widths agree.
package gabella_gain_pkg;

  // Coefficient width shared with the attenuator multiplier; gain is Q1.(MULT_W-1)
  localparam int DEFAULT_MULT_W = 9;

  typedef enum logic [1:0] {
    SETTLED = 2'd0,
    RISING  = 2'd1,
    FALLING = 2'd2,
    MUTED   = 2'd3
  } gain_state_e;

  // Largest representable positive gain (unity itself is not representable)
  function automatic int max_gain(input int mult_w);
    return (1 << (mult_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/gain_ramp_if.sv
// Control/coefficient bundle between the gain source (master) and gain_ramp (slave).
interface gain_ramp_if #(
  parameter int MULT_W = gabella_gain_pkg::DEFAULT_MULT_W
);
  logic              sample_tick_i;
  logic [MULT_W-2:0] target_i;
  logic              mute_i;
  logic [MULT_W-1:0] mult_o;
  logic              busy_o;
  logic              muted_o;

  modport master (
    output sample_tick_i, target_i, mute_i,
    input  mult_o, busy_o, muted_o
  );

  modport slave (
    input  sample_tick_i, target_i, mute_i,
    output mult_o, busy_o, muted_o
  );
endinterface

// File: rtl/gain_step_clamp.sv
// Saturating step of the gain magnitude toward a target, never overshooting it.
// Arithmetic is widened to MULT_W+1 bits so cur+STEP cannot wrap.
module gain_step_clamp #(
  parameter int MULT_W = gabella_gain_pkg::DEFAULT_MULT_W,
  parameter int STEP   = 4
) (
  input  logic [MULT_W-2:0] cur,
  input  logic [MULT_W-2:0] target,
  output logic [MULT_W-2:0] nxt
);
  localparam logic [MULT_W:0] STEP_X = (MULT_W+1)'(STEP);

  logic [MULT_W:0] cur_x;
  logic [MULT_W:0] tgt_x;
  logic [MULT_W:0] up_x;
  logic [MULT_W:0] dn_x;

  assign cur_x = {2'b00, cur};
  assign tgt_x = {2'b00, target};
  assign up_x  = cur_x + STEP_X;
  assign dn_x  = cur_x - STEP_X;

  // Move one step toward target, landing exactly on it when closer than one step
  always_comb begin
    nxt = cur;
    if (cur_x < tgt_x) begin
      nxt = (up_x >= tgt_x) ? target : (MULT_W-1)'(up_x);
    end else if (cur_x > tgt_x) begin
      nxt = (cur_x <= tgt_x + STEP_X) ? target : (MULT_W-1)'(dn_x);
    end
  end
endmodule

// File: rtl/gain_ramp.sv
// Slews the attenuator gain coefficient toward its target by STEP per sample tick,
// with a click-free mute (fade to zero, hold, fade back in).
// Optional build macro GAIN_RAMP_HYST_EN adds a HYST-LSB dead-band on the target latch.
module gain_ramp
  import gabella_gain_pkg::*;
#(
  parameter int MULT_W = DEFAULT_MULT_W,
  parameter int STEP   = 4,
  parameter int HYST   = 2
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  gain_ramp_if.slave bus
);
  localparam int GW = MULT_W - 1;

  // Reject configurations whose step could never settle or whose dead-band is negative
  if (STEP < 1 || STEP > max_gain(MULT_W) || HYST < 0) begin : g_param_check
    $error("gain_ramp: STEP must be 1..max gain and HYST non-negative");
  end

  logic [GW-1:0] cur_reg;
  logic [GW-1:0] cur_next;
  logic [GW-1:0] latch_next;
  logic [GW-1:0] eff;
  gain_state_e   state_reg;
  gain_state_e   state_next;

`ifdef GAIN_RAMP_HYST_EN
  localparam logic [GW-1:0] MAX_G  = GW'(max_gain(MULT_W));
  localparam logic [GW-1:0] HYST_W = GW'(HYST);

  logic [GW-1:0] latch_reg;
  logic [GW-1:0] diff;

  // Accept a new target only outside the dead-band, but always let the end stops through
  always_comb begin
    diff       = (bus.target_i > latch_reg) ? (bus.target_i - latch_reg)
                                            : (latch_reg - bus.target_i);
    latch_next = latch_reg;
    if (diff > HYST_W || bus.target_i == '0 || bus.target_i == MAX_G) begin
      latch_next = bus.target_i;
    end
  end

  // Target latch, updated only on sample ticks
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      latch_reg <= '0;
    end else if (bus.sample_tick_i) begin
      latch_reg <= latch_next;
    end
  end
`else
  assign latch_next = bus.target_i;
`endif

  assign eff = bus.mute_i ? '0 : latch_next;

  gain_step_clamp #(
    .MULT_W (MULT_W),
    .STEP   (STEP)
  ) u_step (
    .cur    (cur_reg),
    .target (eff),
    .nxt    (cur_next)
  );

  // Classify where the new coefficient sits relative to the effective target
  always_comb begin
    if (cur_next < eff) begin
      state_next = RISING;
    end else if (cur_next > eff) begin
      state_next = FALLING;
    end else if (eff == '0 && bus.mute_i) begin
      state_next = MUTED;
    end else begin
      state_next = SETTLED;
    end
  end

  // Coefficient and ramp state advance only on sample ticks; reset gives a muted soft start
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cur_reg   <= '0;
      state_reg <= MUTED;
    end else if (bus.sample_tick_i) begin
      cur_reg   <= cur_next;
      state_reg <= state_next;
    end
  end

  assign bus.mult_o  = {1'b0, cur_reg};
  assign bus.busy_o  = (state_reg == RISING) || (state_reg == FALLING);
  assign bus.muted_o = (state_reg == MUTED);
endmodule

// File: tb/tb_gain_ramp.sv
// Scoreboard bench for gain_ramp: a behavioural model predicts each tick's outputs,
// which are queued and compared once the DUT has registered the tick.
// Build with GAIN_RAMP_HYST_EN defined to also exercise the target dead-band.
module tb_gain_ramp;
  import gabella_gain_pkg::*;

  localparam int MW   = DEFAULT_MULT_W;
  localparam int STEP = 4;
  localparam int HYST = 2;
  localparam int MAXG = (1 << (MW - 1)) - 1;

  typedef struct {
    int mult;
    int busy;
    int muted;
  } exp_t;

  logic clk;
  logic rst_n;
  gain_ramp_if #(.MULT_W(MW)) bus ();

  gain_ramp #(
    .MULT_W (MW),
    .STEP   (STEP),
    .HYST   (HYST)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_cur    = 0;
  int   m_latch  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Reference behaviour for one tick with the currently driven inputs
  task automatic model_tick();
    int tgt;
    int e;
    int d;
    exp_t x;
    tgt = int'(bus.target_i);
`ifdef GAIN_RAMP_HYST_EN
    d = tgt - m_latch;
    if (d < 0) d = -d;
    if (d > HYST || tgt == 0 || tgt == MAXG) m_latch = tgt;
`else
    d = 0;
    m_latch = tgt;
`endif
    e = bus.mute_i ? 0 : m_latch;
    if (m_cur < e) m_cur = (e - m_cur > STEP) ? m_cur + STEP : e;
    else if (m_cur > e) m_cur = (m_cur - e > STEP) ? m_cur - STEP : e;
    x.mult  = m_cur;
    x.busy  = (m_cur != e) ? 1 : 0;
    x.muted = (m_cur == 0 && e == 0 && bus.mute_i) ? 1 : 0;
    sb.push_back(x);
  endtask

  // One sample tick, then compare the registered outputs and idle to an 8-clock spacing
  task automatic tick(input string tag);
    exp_t x;
    bus.sample_tick_i = 1'b1;
    model_tick();
    @(posedge clk);
    #1;
    bus.sample_tick_i = 1'b0;
    if (sb.size() == 0) begin
      check_val({tag, ".sb_empty"}, 1, 0);
    end else begin
      x = sb.pop_front();
      check_val({tag, ".mult"},  int'(bus.mult_o),  x.mult);
      check_val({tag, ".busy"},  int'(bus.busy_o),  x.busy);
      check_val({tag, ".muted"}, int'(bus.muted_o), x.muted);
    end
    repeat (7) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) tick($sformatf("%s[%0d]", tag, i));
  endtask

  // Direct comparison against hand-derived constants
  task automatic expect_out(input string tag, input int mult, input int busy, input int muted);
    check_val({tag, ".mult"},  int'(bus.mult_o),  mult);
    check_val({tag, ".busy"},  int'(bus.busy_o),  busy);
    check_val({tag, ".muted"}, int'(bus.muted_o), muted);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sample_tick_i = 1'b0;
    bus.target_i      = '0;
    bus.mute_i        = 1'b0;
    rst_n             = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    expect_out("reset", 0, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ramp 0 -> 100 in 25 steps of 4
    bus.target_i = 8'd100;
    ticks("up100", 24);
    expect_out("up100_pre", 96, 1, 0);
    tick("up100_last");
    expect_out("up100_done", 100, 0, 0);

    // Back to 0, then a short ramp to 10 that must clamp
    bus.target_i = 8'd0;
    ticks("down0", 25);
    expect_out("down0_done", 0, 0, 0);
    bus.target_i = 8'd10;
    tick("to10a");
    expect_out("to10a_c", 4, 1, 0);
    tick("to10b");
    expect_out("to10b_c", 8, 1, 0);
    tick("to10c");
    expect_out("to10c_c", 10, 0, 0);

    // Full scale, then down to 0 with the last odd remainder
    bus.target_i = 8'(MAXG);
    ticks("to255", 62);
    expect_out("to255_done", 255, 0, 0);
    bus.target_i = 8'd0;
    ticks("from255", 63);
    expect_out("from255_at3", 3, 1, 0);
    tick("from255_last");
    expect_out("from255_zero", 0, 0, 0);
    ticks("hold0", 3);
    expect_out("hold0_c", 0, 0, 0);

    // Mute mid-ramp redirects from 60 without a jump, unmute ramps back
    bus.target_i = 8'd200;
    ticks("to60", 15);
    expect_out("at60", 60, 1, 0);
    bus.mute_i = 1'b1;
    tick("mute_first");
    expect_out("mute_56", 56, 1, 0);
    ticks("mute_fade", 14);
    expect_out("muted", 0, 0, 1);
    bus.mute_i = 1'b0;
    ticks("unmute", 50);
    expect_out("unmute_done", 200, 0, 0);

    // Ticks stop mid-ramp: outputs must freeze while inputs wiggle
    bus.target_i = 8'd100;
    ticks("to160", 10);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      bus.target_i = (i % 2 != 0) ? 8'd30 : 8'd220;
      bus.mute_i   = (i % 3 == 0);
      check_val($sformatf("freeze[%0d].mult", i), int'(bus.mult_o), 160);
      check_val($sformatf("freeze[%0d].busy", i), int'(bus.busy_o), 1);
    end

    // Asynchronous reset away from any clock edge
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 0, 0, 1);
    m_cur   = 0;
    m_latch = 0;
    sb.delete();
    bus.mute_i   = 1'b0;
    bus.target_i = 8'd100;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tick("soft_start");
    expect_out("soft_start_c", 4, 1, 0);
    ticks("resettle", 24);
    expect_out("resettle_c", 100, 0, 0);

`ifdef GAIN_RAMP_HYST_EN
    // Jitter inside the dead-band is ignored; larger moves and end stops pass
    for (int i = 0; i < 6; i++) begin
      bus.target_i = (i % 2 == 0) ? 8'd101 : 8'd99;
      tick($sformatf("jitter[%0d]", i));
      expect_out($sformatf("jitter_c[%0d]", i), 100, 0, 0);
    end
    bus.target_i = 8'd104;
    tick("hyst104");
    expect_out("hyst104_c", 104, 0, 0);
    bus.target_i = 8'(MAXG);
    ticks("hyst255", 38);
    expect_out("hyst255_c", 255, 0, 0);
`endif

    check_val("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
